// File: rtl/bus_rsp_queue.sv
// In-order response queue between the snooping bus and the Dcache fill ports.
// Slots are allocated at bus grant, filled by core or Dmem, drained in allocation order.
module bus_rsp_queue #(
  parameter int Q_NUM  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 64,
  parameter int CORE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_vld_i,
  input  logic [CORE_W-1:0] alloc_core_i,
  input  logic [63:0]       alloc_addr_i,
  output logic              alloc_rdy_o,
  output logic [PTR_W-1:0]  alloc_ptr_o,
  input  logic              core_fill_vld_i,
  input  logic [PTR_W-1:0]  core_fill_ptr_i,
  input  logic [DATA_W-1:0] core_fill_data_i,
  input  logic              mem_fill_vld_i,
  input  logic [PTR_W-1:0]  mem_fill_ptr_i,
  input  logic [DATA_W-1:0] mem_fill_data_i,
  output logic              wb_vld_o,
  output logic [63:0]       wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              deq_vld_o,
  output logic [CORE_W-1:0] deq_core_o,
  output logic [63:0]       deq_addr_o,
  output logic [DATA_W-1:0] deq_data_o,
  input  logic              deq_ack_i,
  output logic [PTR_W:0]    count_o,
  output logic              err_o
);

  logic [PTR_W:0]    head_q, head_d, tail_q, tail_d;
  logic [Q_NUM-1:0]  wait_q, wait_d, rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [CORE_W-1:0] core_q [Q_NUM];
  logic [63:0]       addr_q [Q_NUM];
  logic [DATA_W-1:0] data_q [Q_NUM];
  logic              wb_vld_q;
  logic [63:0]       wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [PTR_W-1:0] head_idx, tail_idx;
  logic full, empty, alloc_fire, core_ok, mem_ok, fill_err, deq_fire;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign full  = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);
  assign empty = (head_q[PTR_W] == tail_q[PTR_W]) && (head_idx == tail_idx);

  assign alloc_fire = alloc_vld_i && !full;
  assign core_ok    = core_fill_vld_i && wait_q[core_fill_ptr_i];
  // Owner core holds the freshest copy, so a colliding mem fill is silently dropped.
  assign mem_ok     = mem_fill_vld_i && wait_q[mem_fill_ptr_i] &&
                      !(core_ok && (mem_fill_ptr_i == core_fill_ptr_i));
  assign fill_err   = (core_fill_vld_i && !wait_q[core_fill_ptr_i]) ||
                      (mem_fill_vld_i && !wait_q[mem_fill_ptr_i]);
  assign deq_fire   = deq_vld_o && deq_ack_i;

  always_comb begin
    wait_d = wait_q;
    rdy_d  = rdy_q;
    if (alloc_fire) wait_d[tail_idx] = 1'b1;
    if (core_ok) begin
      wait_d[core_fill_ptr_i] = 1'b0;
      rdy_d[core_fill_ptr_i]  = 1'b1;
    end
    if (mem_ok) begin
      wait_d[mem_fill_ptr_i] = 1'b0;
      rdy_d[mem_fill_ptr_i]  = 1'b1;
    end
    if (deq_fire) rdy_d[head_idx] = 1'b0;
  end

  assign head_d = head_q + {{PTR_W{1'b0}}, deq_fire};
  assign tail_d = tail_q + {{PTR_W{1'b0}}, alloc_fire};
  assign err_d  = err_q || fill_err || (alloc_vld_i && full);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      wait_q    <= '0;
      rdy_q     <= '0;
      err_q     <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < Q_NUM; i++) begin
        core_q[i] <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      wait_q   <= wait_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      wb_vld_q <= core_ok;
      if (core_ok) begin
        wb_addr_q               <= addr_q[core_fill_ptr_i];
        wb_data_q               <= core_fill_data_i;
        data_q[core_fill_ptr_i] <= core_fill_data_i;
      end
      if (mem_ok) data_q[mem_fill_ptr_i] <= mem_fill_data_i;
      if (alloc_fire) begin
        core_q[tail_idx] <= alloc_core_i;
        addr_q[tail_idx] <= alloc_addr_i;
      end
    end
  end

  assign alloc_rdy_o = !full;
  assign alloc_ptr_o = tail_idx;
  assign wb_vld_o    = wb_vld_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign deq_vld_o   = !empty && rdy_q[head_idx];
  assign deq_core_o  = core_q[head_idx];
  assign deq_addr_o  = addr_q[head_idx];
  assign deq_data_o  = data_q[head_idx];
  assign count_o     = tail_q - head_q;
  assign err_o       = err_q;

endmodule

// File: doc/bus_rsp_queue.md
Name: bus_rsp_queue

Overview:
- In-order response queue between the snooping bus and the cores' Dcache fill ports.
- Allocates one slot per granted data-bearing bus request (GET_S/GET_M); the slot pointer travels with the request to the Dmem controller.
- Each slot is filled either by the owning core (cache-to-cache) or by the Dmem controller response, then drained strictly in allocation order.
- Core-supplied fills are also forwarded as a writeback notice so the Dmem controller can complete pending dirty-line stores.

Parameters:
- Q_NUM, 8, number of queue slots (power of 2).
- PTR_W, 3, log2(Q_NUM); matches the bus response-pointer width.
- DATA_W, 64, line/word data width.
- CORE_W, 1, core-ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- alloc_vld_i  in  1  granted bus request needs a response slot.
- alloc_core_i  in  CORE_W  requesting core.
- alloc_addr_i  in  64  block address of the request.
- alloc_rdy_o  out  1  slot available (not full).
- alloc_ptr_o  out  PTR_W  slot index to be allocated (current tail).
- core_fill_vld_i  in  1  owner core supplies data.
- core_fill_ptr_i  in  PTR_W  target slot.
- core_fill_data_i  in  DATA_W  data.
- mem_fill_vld_i  in  1  Dmem controller response valid.
- mem_fill_ptr_i  in  PTR_W  target slot.
- mem_fill_data_i  in  DATA_W  data.
- wb_vld_o  out  1  writeback notice to Dmem controller.
- wb_addr_o  out  64  address of the forwarded core data.
- wb_data_o  out  DATA_W  forwarded core data.
- deq_vld_o  out  1  head slot ready.
- deq_core_o  out  CORE_W  destination core.
- deq_addr_o  out  64  head address.
- deq_data_o  out  DATA_W  head data.
- deq_ack_i  in  1  destination consumed head.
- count_o  out  PTR_W+1  occupied slots.
- err_o  out  1  sticky protocol error.

Behaviour:
- Storage: circular buffer with head/tail pointers plus wrap MSBs.
  - full = MSBs differ and head == tail; empty = MSBs equal and head == tail.
- Per-slot state:
  - FREE→WAIT on alloc.
  - WAIT→READY on fill.
  - READY→FREE on dequeue.
- Alloc:
  - alloc_rdy_o = ~full, computed from registered state only; a slot freed by deq in the same cycle is not reusable until the next cycle.
  - When alloc_vld_i && alloc_rdy_o: slot[tail] gets core, addr, WAIT; tail advances, wrapping Q_NUM-1→0 and toggling the MSB.
  - alloc_ptr_o = tail, combinational.
  - alloc_vld_i while full: dropped, err_o set.
- Fill:
  - A fill to a WAIT slot latches data and sets READY at the next edge.
  - A fill to a FREE or READY slot is ignored and sets err_o.
  - This includes a fill targeting the slot being allocated in the same cycle, which is still FREE when sampled.
  - Core and mem fills to different slots in the same cycle are both applied.
  - Core and mem fills to the same slot in the same cycle: core data wins, mem data is discarded, no error (the owner holds the freshest copy).
- Writeback notice:
  - For every accepted core fill at cycle N, wb_vld_o=1 at N+1 for exactly one cycle.
  - wb_addr_o = slot addr, wb_data_o = fill data (registered).
  - Ignored core fills produce no notice.
- Dequeue:
  - deq_vld_o = ~empty && slot[head]==READY, driven from registers; head fields are presented combinationally.
  - A slot filled at edge N is visible at the head from cycle N onward; minimum alloc→deq latency is 2 cycles.
  - On deq_vld_o && deq_ack_i: slot[head]→FREE, head advances with wrap/MSB.
  - deq_ack_i without deq_vld_o is ignored.
  - The head waits in WAIT even if later slots are READY (strict order).
- Simultaneous alloc + deq: both applied; count unchanged.
- count_o = tail - head, using the MSB-extended pointers.
- Reset: all slots FREE; head=tail=0, MSBs=0; all outputs 0 except alloc_rdy_o=1; err_o cleared.
- Reset mid-operation discards all in-flight slots and any pending wb notice.

Test Plan:
- Reset, alloc core0 addr 0x100 at ptr 0, mem fill ptr0 data 0xAA next cycle → deq_vld_o=1 one cycle later with core0/0x100/0xAA; ack → count_o=0.
- Alloc ptrs 0,1,2; fill order 2,0,1 → deq order 0,1,2; deq_vld_o low while slot 0 is WAIT despite slot 2 READY.
- Core fill ptr1 data 0x55 with slot addr 0x240 → next cycle wb_vld_o=1, wb_addr_o=0x240, wb_data_o=0x55, single pulse; deq later gives 0x55.
- Core and mem fill same WAIT slot in one cycle (0x11 vs 0x22) → data 0x11, err_o=0, single wb pulse.
- Fill 8 slots (full, alloc_rdy_o=0, count_o=8); alloc+deq in same cycle → alloc dropped, err_o=1; next cycle alloc_rdy_o=1, tail wraps to 0 with MSB toggled.
- Mem fill to FREE ptr 5 → err_o=1 sticky, no state change; rst mid-queue → count_o=0, deq_vld_o=0, err_o=0.
